aes_decrypt_core: RTL and testbench
===================================

# aes_decrypt_core

Iterative AES-128 decryption engine, the inverse counterpart of the team's AES-128 encryption core. It accepts a 128-bit ciphertext and cipher key on a start handshake and runs a forward key expansion to obtain the round-10 key. It then runs 10 inverse rounds, one per clock, with on-the-fly inverse key scheduling, and presents the plaintext with a one-cycle done pulse. It sits alongside the encryptor under the same controller/testbench and uses the same FIPS-197 byte ordering.

## Interface
- No parameters. Key size is fixed at 128 bits and Nr = 10.
- clk  in  1  clock; all state updates on the rising edge
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only when ready=1
- cipher_text  in  128  ciphertext; byte 0 = [127:120], column-major per FIPS-197
- cipher_key  in  128  AES-128 key, same byte order
- ready  out  1  high in IDLE; start is accepted when ready&start
- busy  out  1  equals ~ready
- done  out  1  one-cycle pulse when plain_text is updated
- plain_text  out  128  result register; holds its value until the next completion

## Operation
- States:
  - IDLE
  - KEXP: forward expansion, kcnt 1..10
  - ADDK: initial AddRoundKey with k10
  - ROUND: rnd 9..1
  - FINAL: rnd 0
- Reset values: state=IDLE, ready=1, busy=0, done=0, plain_text=0, internal data/key/counters=0.
- IDLE, start=1:
  - Capture cipher_text into the data register and cipher_key into the key register.
  - Set kcnt=1 and go to KEXP.
- KEXP:
  - Each cycle applies the forward key step (RotWord, SubWord, Rcon[kcnt]) to the key register; kcnt increments.
  - After kcnt=10 the key register holds k10; go to ADDK.
- ADDK: data ^= k10; rnd=9; go to ROUND.
- ROUND, each cycle:
  - Compute k_rnd from the key register k_rnd+1 with the inverse key step: w3'=w3^w2, w2'=w2^w1, w1'=w1^w0, w0'=w0^SubWord(RotWord(w3'))^Rcon[rnd+1].
  - data = InvMixColumns(InvSubBytes(InvShiftRows(data)) ^ k_rnd); key register = k_rnd.
  - Decrement rnd; leave for FINAL after rnd=1.
- FINAL:
  - Derive k0 the same way.
  - plain_text = InvSubBytes(InvShiftRows(data)) ^ k0.
  - Set done=1 and return to IDLE.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36 in the MSB byte of the word. All GF(2^8) arithmetic uses modulus 0x11b.
- cipher_text and cipher_key are ignored outside the accept cycle.
- start while busy is ignored and has no queuing.
- Asserting rstn low mid-operation aborts immediately to reset values. No partial result is ever driven.

## Timing
- Accept edge = T0. KEXP occupies edges T1..T10, ADDK T11, ROUND T12..T20, FINAL T21.
- done=1 and the new plain_text are visible in the cycle after T21. Fixed latency is 21 clocks from the accept edge to done.
- ready returns high in the same cycle that done=1.
- A start in that cycle is accepted, giving back-to-back throughput of one block per 21 cycles. plain_text keeps the previous result until the next T21.
- done is a registered signal, never combinational from start.

## Structure
- Shared package aes_pkg holds:
  - forward and inverse S-box functions
  - the xtime/gmul helpers (x2, x9, x11, x13, x14)
  - the Rcon lookup
  - the FSM state encoding (IDLE, KEXP, ADDK, ROUND, FINAL)
- The encryptor's blocks reuse the forward S-box and xtime from this package.
- Sub-module aes_inv_round is a combinational block with inputs data, key_next and rnd, and a last flag that bypasses InvMixColumns. It returns the new data and k_rnd.
- The FSM, counters and registers live in aes_decrypt_core.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> plain_text 00112233445566778899aabbccddeeff, done exactly 21 clocks after the accept edge.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> 3243f6a8885a308d313198a2e0370734.
- All-zero key, ct 66e94bd4ef8a2c3b884cfa59ca342b2e -> plain_text all zero.
- Back-to-back run:
  - Hold start=1 continuously with C.1 then B vectors -> two done pulses 21 cycles apart with both correct.
  - ready=1 only in the IDLE/done cycles.
  - Input changes while busy have no effect.
- Reset mid-operation: assert rstn low at T15 -> plain_text=0, done=0, ready=1 immediately. A fresh C.1 run afterwards decrypts correctly.
- Loopback: 100 random key/plaintext pairs through the team's encryptor then this block -> the original plaintext is recovered every time.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 helpers: S-boxes, GF(2^8) multipliers, Rcon, key step, FSM encoding.
package aes_pkg;

    typedef enum logic [2:0] {IDLE, KEXP, ADDK, ROUND, FINAL} state_e;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    // Multiply by x modulo x^8+x^4+x^3+x+1 (0x11b).
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] x2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] x9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] x11(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] x13(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] x14(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    // Round constant for key-schedule step i (1..10), placed in the MSB byte.
    function automatic logic [31:0] rcon(input logic [3:0] i);
        logic [7:0] rc;
        case (i)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return {rc, 24'h0};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // One forward AES-128 key-schedule step: k_{i-1} -> k_i.
    function automatic logic [127:0] key_step_fwd(input logic [127:0] k, input logic [3:0] i);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ rcon(i);
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0]  ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational inverse round: rewinds the key one step and applies
// InvShiftRows, InvSubBytes, AddRoundKey and (unless last) InvMixColumns.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] data_i,
    input  logic [127:0] key_next_i,
    input  logic [3:0]   rnd_i,
    input  logic         last_i,
    output logic [127:0] data_o,
    output logic [127:0] key_o
);

    logic [31:0]  w3_r, w2_r, w1_r, w0_r;
    logic [127:0] ark;
    logic [127:0] mixed;

    // Byte (r, c) lives at index 4*c + r, byte 0 in the MSBs.
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c+4-r)%4)+r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a, b, c, d;
        {a, b, c, d} = col;
        return {x14(a) ^ x11(b) ^ x13(c) ^ x9(d),
                x9(a)  ^ x14(b) ^ x11(c) ^ x13(d),
                x13(a) ^ x9(b)  ^ x14(c) ^ x11(d),
                x11(a) ^ x13(b) ^ x9(c)  ^ x14(d)};
    endfunction

    // Inverse key step recovers k_rnd from k_rnd+1.
    assign w3_r  = key_next_i[31:0]  ^ key_next_i[63:32];
    assign w2_r  = key_next_i[63:32] ^ key_next_i[95:64];
    assign w1_r  = key_next_i[95:64] ^ key_next_i[127:96];
    assign w0_r  = key_next_i[127:96] ^ sub_word(rot_word(w3_r)) ^ rcon(rnd_i + 4'd1);
    assign key_o = {w0_r, w1_r, w2_r, w3_r};

    // Round datapath; the last round skips InvMixColumns.
    always_comb begin
        ark   = inv_shift_sub(data_i) ^ key_o;
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            mixed[127-32*c -: 32] = inv_mix_column(ark[127-32*c -: 32]);
        end
        data_o = last_i ? ark : mixed;
    end

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 decryptor: forward key expansion to k10, then one
// inverse round per clock with on-the-fly inverse key scheduling.
module aes_decrypt_core
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic [127:0] cipher_text,
    input  logic [127:0] cipher_key,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [127:0] plain_text
);

    state_e       state_q, state_d;
    logic [127:0] data_q, data_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   kcnt_q, kcnt_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] plain_q, plain_d;
    logic         done_q, done_d;
    logic [127:0] round_data, round_key;

    aes_inv_round u_round (
        .data_i     (data_q),
        .key_next_i (key_q),
        .rnd_i      (rnd_q),
        .last_i     (state_q == FINAL),
        .data_o     (round_data),
        .key_o      (round_key)
    );

    // Next-state logic: sequencing through expansion, rounds and completion.
    always_comb begin
        // NOTE: every _d defaults to its _q first so no path can infer a latch.
        state_d = state_q;
        data_d  = data_q;
        key_d   = key_q;
        kcnt_d  = kcnt_q;
        rnd_d   = rnd_q;
        plain_d = plain_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    data_d  = cipher_text;
                    key_d   = cipher_key;
                    kcnt_d  = 4'd1;
                    state_d = KEXP;
                end
            end
            KEXP: begin
                key_d  = key_step_fwd(key_q, kcnt_q);
                kcnt_d = kcnt_q + 4'd1;
                if (kcnt_q == 4'd10) state_d = ADDK;
            end
            ADDK: begin
                data_d  = data_q ^ key_q;
                rnd_d   = 4'd9;
                state_d = ROUND;
            end
            ROUND: begin
                data_d = round_data;
                key_d  = round_key;
                rnd_d  = rnd_q - 4'd1;
                if (rnd_q == 4'd1) state_d = FINAL;
            end
            FINAL: begin
                key_d   = round_key;
                plain_d = round_data;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: data/key are reset too so an aborted block leaves no secret material behind.
            state_q <= IDLE;
            data_q  <= '0;
            key_q   <= '0;
            kcnt_q  <= '0;
            rnd_q   <= '0;
            plain_q <= '0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_d;
            data_q  <= data_d;
            key_q   <= key_d;
            kcnt_q  <= kcnt_d;
            rnd_q   <= rnd_d;
            plain_q <= plain_d;
            done_q  <= done_d;
        end
    end

    assign ready      = (state_q == IDLE);
    assign busy       = ~ready;
    assign done       = done_q;
    assign plain_text = plain_q;

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Self-checking bench for aes_decrypt_core: FIPS-197 vectors, back-to-back,
// mid-operation reset and random loopback through a behavioural encryptor.
module tb_aes_decrypt_core;

    logic         clk;
    logic         rstn;
    logic         start;
    logic [127:0] cipher_text;
    logic [127:0] cipher_key;
    logic         ready;
    logic         busy;
    logic         done;
    logic [127:0] plain_text;

    int errors = 0;
    int checks = 0;

    logic [7:0]   sbox_t [256];
    logic [31:0]  w_t    [44];
    logic [127:0] last_pt;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes_decrypt_core dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .cipher_text (cipher_text),
        .cipher_key  (cipher_key),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .plain_text  (plain_text)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [8:0] t;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            t = {aa, 1'b0};
            if (t[8]) t ^= 9'h11b;
            aa = t[7:0];
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w_t[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w_t[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            w_t[i] = w_t[i-4] ^ t;
        end
    endtask

    function automatic logic [127:0] round_key(input int r);
        return {w_t[4*r], w_t[4*r+1], w_t[4*r+2], w_t[4*r+3]};
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = sbox_t[s[127-8*(4*((c+r)%4)+r) -: 8]];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [7:0]   m [4];
        logic [127:0] o;
        logic [7:0]   acc;
        m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc ^= gf_mul(m[(j - r + 4) % 4], s[127-8*(4*c+j) -: 8]);
                end
                o[127-8*(4*c+r) -: 8] = acc;
            end
        end
        return o;
    endfunction

    // Encryptor reference: expand_key must have been called for the key in use.
    function automatic logic [127:0] model_encrypt(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ round_key(0);
        for (int r = 1; r < 10; r++) s = mix_columns(sub_shift(s)) ^ round_key(r);
        return sub_shift(s) ^ round_key(10);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- stimulus helpers ----------------
    // Counts cycles from the accept edge to done; optionally scrambles inputs while busy.
    task automatic wait_done(input string tag, input logic [127:0] hold_val, input bit scramble);
        int n;
        int bad_ready;
        int bad_hold;
        n = 0;
        bad_ready = 0;
        bad_hold = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (done) begin
                if (scramble) start = 1'b0;
                break;
            end
            if (ready || !busy) bad_ready++;
            if (plain_text !== hold_val) bad_hold++;
            if (scramble) begin
                cipher_text = rand128();
                cipher_key  = rand128();
                start       = 1'($urandom_range(0, 1));
            end
        end
        check({tag, " latency"}, 128'(n), 128'd21);
        check({tag, " ready low while busy"}, 128'(bad_ready), 128'd0);
        check({tag, " plain_text held"}, 128'(bad_hold), 128'd0);
        check({tag, " ready at done"}, 128'(ready), 128'd1);
    endtask

    task automatic run_block(input string tag, input logic [127:0] key,
                             input logic [127:0] ct, input logic [127:0] exp_pt);
        @(negedge clk);
        cipher_key  = key;
        cipher_text = ct;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(tag, last_pt, 1'b1);
        check({tag, " plain_text"}, plain_text, exp_pt);
        last_pt = exp_pt;
        @(posedge clk);
        #1;
        check({tag, " done single pulse"}, 128'(done), 128'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rstn        = 1'b0;
        start       = 1'b0;
        cipher_text = '0;
        cipher_key  = '0;
        last_pt     = '0;
        build_sbox();

        // Reset state
        #12;
        check("reset ready", 128'(ready), 128'd1);
        check("reset busy", 128'(busy), 128'd0);
        check("reset done", 128'(done), 128'd0);
        check("reset plain_text", plain_text, 128'd0);
        @(negedge clk);
        rstn = 1'b1;

        // FIPS-197 vectors and the all-zero key
        run_block("C1", C1_KEY, C1_CT, C1_PT);
        run_block("B", B_KEY, B_CT, B_PT);
        run_block("zero key", 128'd0, Z_CT, 128'd0);

        // Back-to-back with start held high
        @(negedge clk);
        cipher_key  = C1_KEY;
        cipher_text = C1_CT;
        start       = 1'b1;
        @(posedge clk);
        #1;
        cipher_key  = B_KEY;
        cipher_text = B_CT;
        wait_done("b2b first", last_pt, 1'b0);
        check("b2b first plain_text", plain_text, C1_PT);
        last_pt = C1_PT;
        @(posedge clk);
        #1;
        check("b2b second accepted", 128'(busy), 128'd1);
        cipher_key  = rand128();
        cipher_text = rand128();
        wait_done("b2b second", last_pt, 1'b0);
        start = 1'b0;
        check("b2b second plain_text", plain_text, B_PT);
        last_pt = B_PT;
        @(posedge clk);
        #1;
        check("b2b no third block", 128'(ready), 128'd1);

        // Reset at T15 aborts immediately
        @(negedge clk);
        cipher_key  = C1_KEY;
        cipher_text = C1_CT;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("abort plain_text", plain_text, 128'd0);
        check("abort done", 128'(done), 128'd0);
        check("abort ready", 128'(ready), 128'd1);
        check("abort busy", 128'(busy), 128'd0);
        last_pt = '0;
        @(negedge clk);
        rstn = 1'b1;
        run_block("C1 after abort", C1_KEY, C1_CT, C1_PT);

        // Random loopback through the behavioural encryptor
        for (int i = 0; i < 100; i++) begin
            logic [127:0] key;
            logic [127:0] pt;
            key = rand128();
            pt  = rand128();
            expand_key(key);
            run_block($sformatf("loop%0d", i), key, model_encrypt(pt), pt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
